// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core's memory stage and the load/store unit.
// The LSU sits on the slave modport. The core or testbench drives the master side.
interface dmem_lsu_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_count
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_count
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit with an integrated word-organised data memory.
// Each access runs IDLE -> ACCESS -> RESP. Faulted accesses are counted in a saturating counter.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ERR_CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]           r_state;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_errCount;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic          w_badFunct;
    logic          w_misaligned;
    logic          w_outOfRange;
    logic          w_fault;
    logic [AW-1:0] w_wordIdx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_loadData;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_storeData;

    assign w_wordIdx = r_addr[AW+1:2];
    assign w_word    = r_mem[w_wordIdx];
    assign w_byte    = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];

    // Fault detection works on the captured request, so it is stable for the whole ACCESS cycle.
    always_comb begin
        w_badFunct   = r_we ? (r_funct3 > 3'd2)
                            : (r_funct3 == 3'd3 || r_funct3 == 3'd6 || r_funct3 == 3'd7);
        w_misaligned = 1'b0;
        if (r_funct3[1:0] == 2'd1)
            w_misaligned = r_addr[0];
        else if (r_funct3[1:0] == 2'd2)
            w_misaligned = (r_addr[1:0] != 2'b00);
        w_outOfRange = ({1'b0, r_addr} >= MEM_BYTES);
        w_fault      = w_badFunct || w_misaligned || w_outOfRange;
    end

    always_comb begin
        case (r_funct3)
            3'd0:    w_loadData = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_loadData = {{16{w_half[15]}}, w_half};
            3'd2:    w_loadData = w_word;
            3'd4:    w_loadData = {24'h000000, w_byte};
            3'd5:    w_loadData = {16'h0000, w_half};
            default: w_loadData = 32'h0;
        endcase
    end

    // Store data is replicated across lanes, and the byte enables pick the lanes that land.
    always_comb begin
        case (r_funct3[1:0])
            2'd0: begin
                w_byteEn    = 4'b0001 << r_addr[1:0];
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_byteEn    = 4'b0011 << {r_addr[1], 1'b0};
                w_storeData = {2{r_wdata[15:0]}};
            end
            default: begin
                w_byteEn    = 4'b1111;
                w_storeData = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b])
                    r_mem[w_wordIdx][8*b +: 8] <= w_storeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_errCount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_err   <= w_fault;
                    r_rdata <= (w_fault || r_we) ? 32'h0 : w_loadData;
                    if (w_fault && r_errCount != {ERR_CNT_W{1'b1}})
                        r_errCount <= r_errCount + 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.err_count = r_errCount;
endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, multi-cycle corner sequences,
// and random traffic compared against a byte-array reference model.
module tb_dmem_lsu;
    localparam int DEPTH     = 256;
    localparam int MEM_BYTES = 4 * DEPTH;

    logic clk;
    logic reset;

    dmem_lsu_if #(.ERR_CNT_W(8)) bus ();

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t        vecs [18];
    logic [7:0]  refMem [MEM_BYTES];
    int          refErrCnt;
    int          nChecks;
    int          nFail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: byte-addressed memory, access size from funct3, arithmetic sign extension.
    function automatic void refAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int     nBytes;
        bit     legal;
        longint val;
        nBytes = 1 << (int'(f3) % 4);
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = !legal || (addr >= MEM_BYTES) || ((addr % nBytes) != 0);
        rdata  = 32'h0;
        if (err) begin
            if (refErrCnt < 255) refErrCnt++;
            return;
        end
        if (we) begin
            for (int i = 0; i < nBytes; i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < nBytes; i++) val += longint'(refMem[int'(addr) + i]) << (8 * i);
            if (f3 < 3'd4 && nBytes < 4 && val >= (64'sd1 << (8 * nBytes - 1)))
                val -= (64'sd1 << (8 * nBytes));
            rdata = val[31:0];
        end
    endfunction

    // One complete request/response; called at a negedge, returns at a negedge with the unit in IDLE.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] gotRdata, output logic gotErr,
                                 output logic [31:0] expRdata, output logic expErr);
        int waited;
        refAccess(we, f3, addr, wdata, expRdata, expErr);
        checkOutput("reqReadyBefore", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.rsp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("latency", 32'(waited), 32'd1);
        gotRdata = bus.rsp_rdata;
        gotErr   = bus.rsp_err;
        if (!bus.rsp_valid) begin
            bus.rsp_ready = 1'b1;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            bus.req_valid  = (h % 2 == 0);
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'd2;
            bus.req_addr   = 32'h10;
            bus.req_wdata  = 32'h0;
            @(negedge clk);
            checkOutput("holdValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("holdRdata", bus.rsp_rdata, gotRdata);
            checkOutput("holdErr", 32'(bus.rsp_err), 32'(gotErr));
            checkOutput("holdReqReady", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("idleRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idleReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("errCount", 32'(bus.err_count), 32'(refErrCnt));
    endtask

    initial begin
        logic [31:0] gotR, expR, addr;
        logic        gotE, expE, we;
        logic [2:0]  f3;

        nChecks   = 0;
        nFail     = 0;
        refErrCnt = 0;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h00;

        vecs[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'd0, 32'h11,  32'h0000007F, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'h0000007F, 1'b0};
        vecs[4]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEAD7FEF, 1'b0};
        vecs[5]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[7]  = '{1'b1, 3'd2, 32'h20,  32'h11223344, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 32'h22,  32'h00008001, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
        vecs[10] = '{1'b0, 3'd5, 32'h22,  32'h0,        32'h00008001, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'h80013344, 1'b0};
        vecs[12] = '{1'b0, 3'd2, 32'h21,  32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 3'd1, 32'h23,  32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 3'd2, 32'h400, 32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 3'd3, 32'h20,  32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 3'd4, 32'h20,  32'hAAAAAAAA, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'h80013344, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstRdata", bus.rsp_rdata, 32'h0);
        checkOutput("rstErr", 32'(bus.rsp_err), 32'd0);
        checkOutput("rstErrCount", 32'(bus.err_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] preloading memory");
        for (int w = 0; w < DEPTH; w++) begin
            applyStimulus(1'b1, 3'd2, 32'(w * 4), $urandom, 0, gotR, gotE, expR, expE);
            checkOutput("preloadErr", 32'(gotE), 32'd0);
        end

        $display("[TB] directed vectors");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, gotR, gotE, expR, expE);
            checkOutput($sformatf("vec%0d_rdata", i), gotR, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_err", i), 32'(gotE), 32'(vecs[i].expErr));
        end
        checkOutput("errCountFive", 32'(bus.err_count), 32'd5);

        $display("[TB] backpressure hold");
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 4, gotR, gotE, expR, expE);
        checkOutput("holdLoad", gotR, 32'hDEAD7FEF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 0, gotR, gotE, expR, expE);
        checkOutput("pulsesIgnored", gotR, 32'hDEAD7FEF);
        checkOutput("pulsesNoErr", 32'(bus.err_count), 32'd5);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            if ($urandom_range(0, 19) == 0) addr = addr + 32'(MEM_BYTES);
            applyStimulus(we, f3, addr, $urandom, 0, gotR, gotE, expR, expE);
            checkOutput("rndRdata", gotR, expR);
            checkOutput("rndErr", 32'(gotE), 32'(expE));
        end

        $display("[TB] fault saturation");
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 3'd2, 32'h400 + 32'(n % 4), 32'h0, 0, gotR, gotE, expR, expE);
            checkOutput("satErr", 32'(gotE), 32'd1);
        end
        checkOutput("errCountSat", 32'(bus.err_count), 32'd255);

        $display("[TB] reset during access");
        applyStimulus(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 0, gotR, gotE, expR, expE);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        checkOutput("inAccessReqReady", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midRstReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("midRstRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midRstRdata", bus.rsp_rdata, 32'h0);
        checkOutput("midRstErr", 32'(bus.rsp_err), 32'd0);
        checkOutput("midRstErrCount", 32'(bus.err_count), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        refErrCnt = 0;
        @(negedge clk);
        applyStimulus(1'b0, 3'd2, 32'h30, 32'h0, 0, gotR, gotE, expR, expE);
        checkOutput("droppedStore", gotR, 32'hCAFEF00D);
        checkOutput("droppedStoreErr", 32'(gotE), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
